// File: rtl/dec38_arb_if.sv
// Bus bundle between the dec38 arbiter and its clients/decoder.
// The slave side is the arbiter; the master side is whatever drives requests.
interface dec38_arb_if;

  // Client side: level requests and a release strobe from the current owner.
  logic [7:0] req;
  logic       done;

  // Decoder side: code, active-low gate and the matching one-hot grant.
  logic [2:0] sel;
  logic       gn;
  logic [7:0] gnt;
  logic       busy;
  logic       tout;

  modport master (
    output req,
    output done,
    input  sel,
    input  gn,
    input  gnt,
    input  busy,
    input  tout
  );

  modport slave (
    input  req,
    input  done,
    output sel,
    output gn,
    output gnt,
    output busy,
    output tout
  );

endinterface

// File: rtl/dec38_arb.sv
// Round-robin owner sequencer for one 8-way decoded select resource.
// Grants one client at a time, ends the grant on release or timeout, and
// keeps the decoder ungated for a turnaround gap before re-arbitrating.
// sel only changes on the edge that starts a grant, so the decoder inputs
// stay quiet whenever the gate is high.
module dec38_arb #(
  parameter int unsigned MAXHOLD = 15,
  parameter int unsigned TURN    = 1
) (
  input  logic        sys_clk,
  input  logic        reset,
  dec38_arb_if.slave  bus
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned TURN_W = 2;
  localparam int unsigned NCLI   = 8;

  // A zero MAXHOLD disables the timeout; a zero TURN skips the TURN state.
  localparam bit                 HOLD_EN   = (MAXHOLD != 0);
  localparam logic [CNT_W-1:0]   HOLD_LAST = HOLD_EN ? CNT_W'(MAXHOLD - 1) : '0;
  localparam bit                 TURN_EN   = (TURN != 0);
  localparam logic [TURN_W-1:0]  TURN_LAST = TURN_EN ? TURN_W'(TURN - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TURN_W-1:0]  turn_q, turn_d;
  logic [2:0]         last_q, last_d;

  logic [2:0]         sel_q, sel_d;
  logic               gn_q, gn_d;
  logic [NCLI-1:0]    gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               tout_q, tout_d;

  logic [2:0]         start_c;
  logic [NCLI-1:0]    rot_c;
  logic               found_c;
  logic [2:0]         idx_c;
  logic [2:0]         winner_c;
  logic               rel_c;
  logic               tmo_c;

  // Round-robin pick: rotate requests so last+1 lands on bit 0, take the first set bit.
  always_comb begin
    start_c  = last_q + 3'd1;
    rot_c    = NCLI'({bus.req, bus.req} >> start_c);
    found_c  = 1'b0;
    idx_c    = '0;
    for (int i = 0; i < int'(NCLI); i++) begin
      if (!found_c && rot_c[i]) begin
        found_c = 1'b1;
        idx_c   = 3'(i);
      end
    end
    winner_c = idx_c + start_c;
  end

  // Grant exit conditions; a release always takes priority over a timeout.
  always_comb begin
    rel_c = bus.done | ~bus.req[sel_q];
    tmo_c = HOLD_EN && (cnt_q == HOLD_LAST);
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      turn_q  <= '0;
      last_q  <= 3'd7;
      sel_q   <= '0;
      gn_q    <= 1'b1;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      turn_q  <= turn_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gn_q    <= gn_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      tout_q  <= tout_d;
    end
  end

  // Next-state: arbitrate in IDLE, count the grant, count down the turnaround.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    turn_d  = turn_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d = ST_GRANT;
          last_d  = winner_c;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (rel_c || tmo_c) begin
          state_d = TURN_EN ? ST_TURN : ST_IDLE;
          turn_d  = TURN_LAST;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TURN: begin
        if (turn_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          turn_d = turn_q - TURN_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next values, derived from the transition being taken.
  always_comb begin
    sel_d  = sel_q;
    gn_d   = 1'b1;
    gnt_d  = '0;
    busy_d = 1'b0;
    tout_d = 1'b0;
    if (state_q == ST_IDLE && state_d == ST_GRANT) begin
      sel_d = winner_c;
    end
    gn_d   = (state_d != ST_GRANT);
    gnt_d  = gn_d ? '0 : NCLI'(NCLI'(1) << sel_d);
    busy_d = (state_d != ST_IDLE);
    tout_d = (state_q == ST_GRANT) && !rel_c && tmo_c;
  end

  assign bus.sel  = sel_q;
  assign bus.gn   = gn_q;
  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.tout = tout_q;

endmodule

// File: tb/tb_dec38_arb.sv
// Bench for dec38_arb: two instances (MAXHOLD 15 and 4, TURN 1) share one
// stimulus; a grant-level model of each is compared on every falling edge,
// and directed sequences pin the model with literal expectations.
module tb_dec38_arb;

  localparam int TURN_P = 1;
  localparam int MH_A   = 15;
  localparam int MH_B   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;

  dec38_arb_if ifa ();
  dec38_arb_if ifb ();

  assign ifa.req  = req;
  assign ifa.done = done;
  assign ifb.req  = req;
  assign ifb.done = done;

  dec38_arb #(.MAXHOLD(MH_A), .TURN(TURN_P)) u_a (.sys_clk(clk), .reset(rst), .bus(ifa));
  dec38_arb #(.MAXHOLD(MH_B), .TURN(TURN_P)) u_b (.sys_clk(clk), .reset(rst), .bus(ifb));

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 owned, 2 turnaround; held = cycles owned so far.
  typedef struct {
    int   phase;
    int   sel;
    int   last;
    int   held;
    int   tleft;
    logic tout;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mreset();
    mdl_t n;
    n.phase = 0; n.sel = 0; n.last = 7; n.held = 0; n.tleft = 0; n.tout = 1'b0;
    return n;
  endfunction

  function automatic mdl_t mstep(input mdl_t s, input logic [7:0] r, input logic d,
                                 input int mh, input int tn);
    mdl_t n;
    n = s;
    n.tout = 1'b0;
    case (s.phase)
      0: begin
        for (int k = 1; k <= 8; k++) begin
          int c;
          c = (s.last + k) % 8;
          if (r[c] && n.phase == 0) begin
            n.phase = 1; n.sel = c; n.last = c; n.held = 1;
          end
        end
      end
      1: begin
        if (d || !r[s.sel]) begin
          n.phase = (tn > 0) ? 2 : 0; n.tleft = tn;
        end else if (mh != 0 && s.held >= mh) begin
          n.tout = 1'b1; n.phase = (tn > 0) ? 2 : 0; n.tleft = tn;
        end else begin
          n.held = s.held + 1;
        end
      end
      default: begin
        n.tleft = s.tleft - 1;
        if (n.tleft <= 0) n.phase = 0;
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= mreset();
      mb <= mreset();
    end else begin
      ma <= mstep(ma, req, done, MH_A, TURN_P);
      mb <= mstep(mb, req, done, MH_B, TURN_P);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input mdl_t m, input logic [2:0] sel, input logic gn,
                     input logic [7:0] gnt, input logic busy, input logic tout);
    logic       gn_e;
    logic [7:0] gnt_e;
    gn_e  = (m.phase != 1);
    gnt_e = gn_e ? 8'h00 : 8'(8'h01 << m.sel);
    chk({tag, "_sel"},  32'(sel),  32'(m.sel));
    chk({tag, "_gn"},   32'(gn),   32'(gn_e));
    chk({tag, "_gnt"},  32'(gnt),  32'(gnt_e));
    chk({tag, "_busy"}, 32'(busy), 32'(m.phase != 0));
    chk({tag, "_tout"}, 32'(tout), 32'(m.tout));
    chk({tag, "_inv"},  32'(gnt),  32'(gn ? 8'h00 : 8'(8'h01 << sel)));
    chk({tag, "_oh"},   32'($onehot0(gnt)), 32'd1);
  endtask

  // Fairness: count other clients' grants while a request stays asserted.
  int   wcnt [2][8];
  logic pgn  [2];

  task automatic fair(input int k, input logic gn, input logic [7:0] gnt);
    if (rst) begin
      for (int c = 0; c < 8; c++) wcnt[k][c] = 0;
    end else begin
      for (int c = 0; c < 8; c++) if (!req[c]) wcnt[k][c] = 0;
      if (pgn[k] && !gn) begin
        for (int c = 0; c < 8; c++) begin
          if (gnt[c]) wcnt[k][c] = 0;
          else if (req[c]) begin
            wcnt[k][c]++;
            chk(k == 0 ? "a_fair" : "b_fair", 32'(wcnt[k][c] <= 8), 32'd1);
          end
        end
      end
    end
    pgn[k] = gn;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    pgn[0] = 1'b1;
    pgn[1] = 1'b1;
    forever begin
      @(negedge clk);
      cmp("a", ma, ifa.sel, ifa.gn, ifa.gnt, ifa.busy, ifa.tout);
      cmp("b", mb, ifb.sel, ifb.gn, ifb.gnt, ifb.busy, ifb.tout);
      fair(0, ifa.gn, ifa.gnt);
      fair(1, ifb.gn, ifb.gnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  int exp_c [4] = '{0, 7, 0, 7};

  initial begin
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    tick(2);
    chk("rst_sel",  32'(ifa.sel),  32'd0);
    chk("rst_gn",   32'(ifa.gn),   32'd1);
    chk("rst_gnt",  32'(ifa.gnt),  32'h00);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_tout", 32'(ifa.tout), 32'd0);
    rst = 1'b0;

    // Reset in the middle of a grant takes effect at once.
    req = 8'hFF;
    tick(1);
    chk("t1_sel", 32'(ifa.sel), 32'd0);
    chk("t1_gnt", 32'(ifa.gnt), 32'h01);
    tick(2);
    chk("t1_hold_gn", 32'(ifa.gn), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_gn",  32'(ifa.gn),  32'd1);
    chk("t1_async_gnt", 32'(ifa.gnt), 32'h00);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("t1_first_sel", 32'(ifa.sel), 32'd0);
    chk("t1_first_gnt", 32'(ifa.gnt), 32'h01);
    req = 8'h00;
    tick(3);

    // Two requesters alternate; done in each grant's first cycle.
    do_reset();
    req = 8'h81;
    for (int g = 0; g < 4; g++) begin
      tick(1);
      chk("t2_sel", 32'(ifa.sel), 32'(exp_c[g]));
      chk("t2_gnt", 32'(ifa.gnt), 32'(8'h01 << exp_c[g]));
      done = 1'b1;
      tick(1);
      done = 1'b0;
      chk("t2_turn_gn",   32'(ifa.gn),   32'd1);
      chk("t2_turn_busy", 32'(ifa.busy), 32'd1);
      tick(1);
      chk("t2_idle_gn",   32'(ifa.gn),   32'd1);
      chk("t2_idle_busy", 32'(ifa.busy), 32'd0);
    end
    req = 8'h00;
    tick(2);

    // Single client, release in its third grant cycle.
    req = 8'h10;
    tick(1);
    chk("t3_sel", 32'(ifa.sel), 32'd4);
    chk("t3_gnt", 32'(ifa.gnt), 32'h10);
    tick(1);
    chk("t3_c2_gn", 32'(ifa.gn), 32'd0);
    tick(1);
    chk("t3_c3_gn", 32'(ifa.gn), 32'd0);
    done = 1'b1;
    req  = 8'h00;
    tick(1);
    done = 1'b0;
    chk("t3_turn_gn",   32'(ifa.gn),   32'd1);
    chk("t3_turn_busy", 32'(ifa.busy), 32'd1);
    chk("t3_turn_sel",  32'(ifa.sel),  32'd4);
    tick(1);
    chk("t3_idle_busy", 32'(ifa.busy), 32'd0);

    // Timeout at 15 cycles on instance a, then re-grant after the gap.
    req = 8'h04;
    tick(1);
    chk("t4_sel", 32'(ifa.sel), 32'd2);
    chk("t4_gn",  32'(ifa.gn),  32'd0);
    for (int k = 1; k < 15; k++) begin
      tick(1);
      chk("t4_hold_gn",   32'(ifa.gn),   32'd0);
      chk("t4_hold_tout", 32'(ifa.tout), 32'd0);
    end
    tick(1);
    chk("t4_end_gn",   32'(ifa.gn),   32'd1);
    chk("t4_end_tout", 32'(ifa.tout), 32'd1);
    tick(1);
    chk("t4_idle_tout", 32'(ifa.tout), 32'd0);
    chk("t4_idle_busy", 32'(ifa.busy), 32'd0);
    tick(1);
    chk("t4_regrant_gn",  32'(ifa.gn),  32'd0);
    chk("t4_regrant_sel", 32'(ifa.sel), 32'd2);
    req = 8'h00;
    tick(4);

    // Instance b (MAXHOLD 4): done coinciding with the last cycle wins.
    req = 8'h04;
    tick(1);
    chk("t5_gn", 32'(ifb.gn), 32'd0);
    tick(3);
    chk("t5_c4_gn", 32'(ifb.gn), 32'd0);
    done = 1'b1;
    req  = 8'h00;
    tick(1);
    done = 1'b0;
    chk("t5_rel_gn",   32'(ifb.gn),   32'd1);
    chk("t5_rel_tout", 32'(ifb.tout), 32'd0);
    tick(1);
    req = 8'h04;
    tick(1);
    chk("t5b_gn", 32'(ifb.gn), 32'd0);
    tick(3);
    tick(1);
    chk("t5b_tmo_gn",   32'(ifb.gn),   32'd1);
    chk("t5b_tmo_tout", 32'(ifb.tout), 32'd1);
    req = 8'h00;
    tick(4);

    // Slowly varying random requests with occasional release strobes.
    for (int i = 0; i < 10000; i++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
      done = ($urandom_range(0, 5) == 0);
      tick(1);
    end
    req  = 8'h00;
    done = 1'b0;
    tick(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
